// File: rtl/msu_if_pkg.sv
// Shared word-count and transfer-size helpers for the MSU AXI-stream job protocol.
// Used by both the msu block and its host-side initiator.
package msu_if_pkg;

  // Stand-in for redun_mont_pkg::TOT_BITS so this slice elaborates on its own.
  localparam int unsigned TOT_BITS    = 128;
  localparam int unsigned DEF_AXI_LEN = 32;
  localparam int unsigned DEF_T_LEN   = 64;

  function automatic int unsigned in_count(input int unsigned axi_len,
                                           input int unsigned t_len,
                                           input int unsigned sq_bits);
    return (2 * t_len) / axi_len + sq_bits / axi_len;
  endfunction

  function automatic int unsigned out_count(input int unsigned axi_len,
                                            input int unsigned t_len,
                                            input int unsigned sq_bits);
    return t_len / axi_len + sq_bits / axi_len;
  endfunction

  function automatic int unsigned in_bytes(input int unsigned axi_len,
                                           input int unsigned t_len,
                                           input int unsigned sq_bits);
    return in_count(axi_len, t_len, sq_bits) * axi_len / 8;
  endfunction

  function automatic int unsigned out_bytes(input int unsigned axi_len,
                                            input int unsigned t_len,
                                            input int unsigned sq_bits);
    return out_count(axi_len, t_len, sq_bits) * axi_len / 8;
  endfunction

  localparam int unsigned DEF_IN_BYTES  = in_bytes(DEF_AXI_LEN, DEF_T_LEN, TOT_BITS);
  localparam int unsigned DEF_OUT_BYTES = out_bytes(DEF_AXI_LEN, DEF_T_LEN, TOT_BITS);

endpackage

// File: rtl/msu_stream_host_if.sv
// Job (host->msu) and result (msu->host) AXI-stream pair between the host initiator and msu.
interface msu_stream_host_if #(
  parameter int unsigned AXI_LEN = 32
);
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic [AXI_LEN-1:0]     m_axis_tdata;
  logic [AXI_LEN/8-1:0]   m_axis_tkeep;
  logic                   m_axis_tlast;
  logic                   s_axis_tvalid;
  logic                   s_axis_tready;
  logic [AXI_LEN-1:0]     s_axis_tdata;

  modport master (
    output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, s_axis_tready,
    input  m_axis_tready, s_axis_tvalid, s_axis_tdata
  );

  modport slave (
    input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, s_axis_tready,
    output m_axis_tready, s_axis_tvalid, s_axis_tdata
  );
endinterface

// File: rtl/msu_stream_host.sv
// Host-side MSU initiator: latches a job, streams it out word by word, collects the
// result stream and presents it with the measured cycle count.
module msu_stream_host
  import msu_if_pkg::*;
#(
  parameter int unsigned AXI_LEN           = 32,
  parameter int unsigned C_XFER_SIZE_WIDTH = 32,
  parameter int unsigned T_LEN             = 64,
  parameter int unsigned SQ_BITS           = msu_if_pkg::TOT_BITS
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [T_LEN-1:0]             job_t_start,
  input  logic [T_LEN-1:0]             job_t_final,
  input  logic [SQ_BITS-1:0]           job_sq_in,
  output logic                         ap_start,
  input  logic                         ap_done,
  input  logic [C_XFER_SIZE_WIDTH-1:0] in_xfer_size,
  input  logic [C_XFER_SIZE_WIDTH-1:0] out_xfer_size,
  msu_stream_host_if.master            axis,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [T_LEN-1:0]             res_t,
  output logic [SQ_BITS-1:0]           res_sq,
  output logic [31:0]                  res_cycles,
  output logic                         size_err
);

  localparam int unsigned IN_COUNT  = in_count(AXI_LEN, T_LEN, SQ_BITS);
  localparam int unsigned OUT_COUNT = out_count(AXI_LEN, T_LEN, SQ_BITS);
  localparam int unsigned IN_BYTES  = in_bytes(AXI_LEN, T_LEN, SQ_BITS);
  localparam int unsigned OUT_BYTES = out_bytes(AXI_LEN, T_LEN, SQ_BITS);
  localparam int unsigned MAX_COUNT = (IN_COUNT > OUT_COUNT) ? IN_COUNT : OUT_COUNT;
  localparam int unsigned SR_W      = MAX_COUNT * AXI_LEN;
  localparam int unsigned CNT_W     = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

  typedef enum logic [2:0] {
    IDLE, START, SEND, RECV, WAIT_DONE, RESULT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [31:0]        cyc_d;
  logic               done_seen_q, done_d;
  logic               err_d;
  logic               m_tvalid_q, m_tvalid_d;
  logic               m_tlast_q, m_tlast_d;
  logic               s_tready_q, s_tready_d;
  logic               job_ready_d, ap_start_d, res_valid_d;

  // Next-state, datapath and next-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    cyc_d   = res_cycles;
    err_d   = size_err;
    done_d  = done_seen_q;

    if (ap_done && (state_q inside {SEND, RECV, WAIT_DONE})) done_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (job_valid) begin
          state_d = START;
          sr_d    = SR_W'({job_sq_in, job_t_final, job_t_start});
          cnt_d   = '0;
          cyc_d   = '0;
          err_d   = 1'b0;
          done_d  = 1'b0;
        end
      end
      START: begin
        state_d = SEND;
        err_d   = (in_xfer_size  != C_XFER_SIZE_WIDTH'(IN_BYTES)) ||
                  (out_xfer_size != C_XFER_SIZE_WIDTH'(OUT_BYTES));
      end
      SEND: begin
        cyc_d = res_cycles + 32'(res_cycles != '1);
        if (m_tvalid_q && axis.m_axis_tready) begin
          sr_d = sr_q >> AXI_LEN;
          if (cnt_q == CNT_W'(IN_COUNT - 1)) begin
            cnt_d   = '0;
            state_d = RECV;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RECV: begin
        cyc_d = res_cycles + 32'(res_cycles != '1);
        if (axis.s_axis_tvalid) begin
          // Result words enter at the top so the full result ends up MSB-aligned
          sr_d = {axis.s_axis_tdata, sr_q[SR_W-1:AXI_LEN]};
          if (cnt_q == CNT_W'(OUT_COUNT - 1)) begin
            cnt_d   = '0;
            state_d = WAIT_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WAIT_DONE: if (ap_done || done_seen_q) state_d = RESULT;
      RESULT:    if (res_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    job_ready_d = (state_d == IDLE);
    ap_start_d  = (state_d == START);
    m_tvalid_d  = (state_d == SEND);
    m_tlast_d   = (state_d == SEND) && (cnt_d == CNT_W'(IN_COUNT - 1));
    s_tready_d  = (state_d == RECV);
    res_valid_d = (state_d == RESULT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      res_cycles  <= '0;
      done_seen_q <= 1'b0;
      size_err    <= 1'b0;
      job_ready   <= 1'b1;
      ap_start    <= 1'b0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      s_tready_q  <= 1'b0;
      res_valid   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      res_cycles  <= cyc_d;
      done_seen_q <= done_d;
      size_err    <= err_d;
      job_ready   <= job_ready_d;
      ap_start    <= ap_start_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      s_tready_q  <= s_tready_d;
      res_valid   <= res_valid_d;
    end
  end

  assign axis.m_axis_tvalid = m_tvalid_q;
  assign axis.m_axis_tdata  = sr_q[AXI_LEN-1:0];
  assign axis.m_axis_tkeep  = '1;
  assign axis.m_axis_tlast  = m_tlast_q;
  assign axis.s_axis_tready = s_tready_q;

  assign res_t  = sr_q[SR_W-OUT_COUNT*AXI_LEN +: T_LEN];
  assign res_sq = sr_q[SR_W-SQ_BITS +: SQ_BITS];

endmodule

// File: tb/tb_msu_stream_host.sv
// Directed bench for msu_stream_host: job serialization, backpressure, result reassembly,
// done_seen timing, size_err and mid-transfer reset, checked through word/result scoreboards.
module tb_msu_stream_host;

  localparam int unsigned AXI_LEN   = 32;
  localparam int unsigned T_LEN     = 64;
  localparam int unsigned SQ_BITS   = 128;
  localparam int unsigned XW        = 32;
  localparam int unsigned IN_COUNT  = 8;
  localparam int unsigned OUT_COUNT = 6;
  localparam int unsigned JOB_W     = 2 * T_LEN + SQ_BITS;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               job_valid;
  logic               job_ready;
  logic [T_LEN-1:0]   job_t_start, job_t_final;
  logic [SQ_BITS-1:0] job_sq_in;
  logic               ap_start;
  logic               ap_done;
  logic [XW-1:0]      in_xfer_size, out_xfer_size;
  logic               res_valid, res_ready;
  logic [T_LEN-1:0]   res_t;
  logic [SQ_BITS-1:0] res_sq;
  logic [31:0]        res_cycles;
  logic               size_err;

  msu_stream_host_if #(.AXI_LEN(AXI_LEN)) axis ();

  msu_stream_host #(
    .AXI_LEN(AXI_LEN), .C_XFER_SIZE_WIDTH(XW), .T_LEN(T_LEN), .SQ_BITS(SQ_BITS)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_t_start(job_t_start), .job_t_final(job_t_final), .job_sq_in(job_sq_in),
    .ap_start(ap_start), .ap_done(ap_done),
    .in_xfer_size(in_xfer_size), .out_xfer_size(out_xfer_size),
    .axis(axis),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_t(res_t), .res_sq(res_sq), .res_cycles(res_cycles), .size_err(size_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [T_LEN-1:0]   t;
    logic [SQ_BITS-1:0] sq;
    logic [31:0]        cyc;
  } res_exp_t;

  logic [AXI_LEN-1:0] exp_q[$];
  res_exp_t           res_q[$];
  int unsigned        passed = 0;
  int unsigned        failed = 0;
  int unsigned        total  = 0;
  int unsigned        cyc_model;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_job_ready"}, 256'(job_ready), 256'(1));
    chk({tag, "_ap_start"},  256'(ap_start), 256'(0));
    chk({tag, "_tvalid"},    256'(axis.m_axis_tvalid), 256'(0));
    chk({tag, "_tlast"},     256'(axis.m_axis_tlast), 256'(0));
    chk({tag, "_s_tready"},  256'(axis.s_axis_tready), 256'(0));
    chk({tag, "_res_valid"}, 256'(res_valid), 256'(0));
    chk({tag, "_size_err"},  256'(size_err), 256'(0));
    chk({tag, "_res_cyc"},   256'(res_cycles), 256'(0));
    chk({tag, "_res_t"},     256'(res_t), 256'(0));
    chk({tag, "_res_sq"},    256'(res_sq), 256'(0));
  endtask

  // Offer a job and queue its expected stream words (t_start, t_final, sq_in, LSW first)
  task automatic send_job(input logic [T_LEN-1:0] ts, input logic [T_LEN-1:0] tf,
                          input logic [SQ_BITS-1:0] sq, input logic [XW-1:0] isz);
    logic [JOB_W-1:0] jw;
    @(negedge clk);
    in_xfer_size = isz;
    job_t_start  = ts;
    job_t_final  = tf;
    job_sq_in    = sq;
    job_valid    = 1'b1;
    jw = {sq, tf, ts};
    for (int i = 0; i < int'(IN_COUNT); i++) exp_q.push_back(jw[i*AXI_LEN +: AXI_LEN]);
    chk("job_ready_idle", 256'(job_ready), 256'(1));
    @(negedge clk);
    job_valid = 1'b0;
    chk("ap_start_pulse", 256'(ap_start), 256'(1));
    chk("job_ready_busy", 256'(job_ready), 256'(0));
    @(negedge clk);
    chk("ap_start_drop", 256'(ap_start), 256'(0));
    chk("tvalid_rise", 256'(axis.m_axis_tvalid), 256'(1));
  endtask

  task automatic drain_send(input bit bp);
    int unsigned        tlasts = 0;
    bit                 stalled = 1'b0;
    logic [AXI_LEN-1:0] prev = '0;
    logic [AXI_LEN-1:0] w;
    cyc_model = 0;
    for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
      if (stalled) chk("tdata_stable", 256'(axis.m_axis_tdata), 256'(prev));
      axis.m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (axis.m_axis_tvalid && axis.m_axis_tready) begin
        w = exp_q.pop_front();
        chk("tdata", 256'(axis.m_axis_tdata), 256'(w));
        chk("tlast", 256'(axis.m_axis_tlast), 256'(exp_q.size() == 0));
        if (axis.m_axis_tlast) tlasts++;
        stalled = 1'b0;
      end else begin
        stalled = axis.m_axis_tvalid;
        prev    = axis.m_axis_tdata;
      end
      @(posedge clk);
      cyc_model++;
      @(negedge clk);
    end
    axis.m_axis_tready = 1'b0;
    chk("send_complete", 256'(exp_q.size()), 256'(0));
    chk("tlast_count", 256'(tlasts), 256'(1));
    chk("tvalid_drop", 256'(axis.m_axis_tvalid), 256'(0));
  endtask

  // Feed OUT_COUNT result words (word i = wv[i]); optional idle gap and ap_done pulse
  task automatic recv(input logic [OUT_COUNT*AXI_LEN-1:0] wv, input int done_idx, input int gap_idx);
    res_exp_t r;
    for (int i = 0; i < int'(OUT_COUNT); i++) begin
      if (i == gap_idx) begin
        axis.s_axis_tvalid = 1'b0;
        @(posedge clk);
        cyc_model++;
        @(negedge clk);
      end
      chk("s_tready", 256'(axis.s_axis_tready), 256'(1));
      axis.s_axis_tvalid = 1'b1;
      axis.s_axis_tdata  = wv[i*AXI_LEN +: AXI_LEN];
      ap_done            = (i == done_idx);
      @(posedge clk);
      cyc_model++;
      @(negedge clk);
    end
    axis.s_axis_tvalid = 1'b0;
    ap_done            = 1'b0;
    r.t   = wv[T_LEN-1:0];
    r.sq  = wv[T_LEN +: SQ_BITS];
    r.cyc = cyc_model;
    res_q.push_back(r);
    chk("s_tready_drop", 256'(axis.s_axis_tready), 256'(0));
  endtask

  task automatic finish_result(input bit done_early, input int hold);
    res_exp_t r;
    chk("res_valid_wait", 256'(res_valid), 256'(0));
    if (!done_early) ap_done = 1'b1;
    @(negedge clk);
    ap_done = 1'b0;
    chk("res_valid_rise", 256'(res_valid), 256'(1));
    r = res_q.pop_front();
    chk("res_t", 256'(res_t), 256'(r.t));
    chk("res_sq", 256'(res_sq), 256'(r.sq));
    chk("res_cycles", 256'(res_cycles), 256'(r.cyc));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("res_valid_hold", 256'(res_valid), 256'(1));
      chk("res_t_hold", 256'(res_t), 256'(r.t));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("job_ready_back", 256'(job_ready), 256'(1));
    chk("res_valid_drop", 256'(res_valid), 256'(0));
  endtask

  initial begin
    logic [T_LEN-1:0]             ts, tf;
    logic [SQ_BITS-1:0]           sq;
    logic [OUT_COUNT*AXI_LEN-1:0] wv;

    reset_n = 1'b0;
    job_valid = 1'b0;
    job_t_start = '0; job_t_final = '0; job_sq_in = '0;
    ap_done = 1'b0;
    in_xfer_size = 32'd32;
    out_xfer_size = 32'd24;
    res_ready = 1'b0;
    axis.m_axis_tready = 1'b0;
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tdata  = '0;
    repeat (2) @(negedge clk);
    chk_reset_values("rst");
    reset_n = 1'b1;

    // Directed job, no backpressure: 8 consecutive words, result completed by late ap_done
    send_job(64'h1, 64'h5, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 32'd32);
    chk("size_ok", 256'(size_err), 256'(0));
    drain_send(1'b0);
    chk("send_min_cycles", 256'(cyc_model), 256'(IN_COUNT));
    wv = {32'hD, 32'hC, 32'hB, 32'hA, 32'h0, 32'h5};
    recv(wv, -1, -1);
    finish_result(1'b0, 2);

    // Random data with 50% backpressure, gap in result stream, ap_done seen mid-RECV
    ts = {$urandom, $urandom}; tf = {$urandom, $urandom};
    sq = {$urandom, $urandom, $urandom, $urandom};
    send_job(ts, tf, sq, 32'd32);
    drain_send(1'b1);
    wv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    recv(wv, 2, 3);
    finish_result(1'b1, 1);

    // Wrong in_xfer_size: flagged but transfer completes; next job clears the flag
    send_job(64'h7, 64'h9, 128'h1234, 32'd28);
    chk("size_err_set", 256'(size_err), 256'(1));
    drain_send(1'b1);
    wv = {32'h4, 32'h3, 32'h2, 32'h1, 32'h0, 32'h9};
    recv(wv, -1, -1);
    chk("size_err_sticky", 256'(size_err), 256'(1));
    finish_result(1'b0, 0);
    send_job(64'h2, 64'h3, 128'h55, 32'd32);
    chk("size_err_clear", 256'(size_err), 256'(0));
    drain_send(1'b0);
    recv({32'h11, 32'h22, 32'h33, 32'h44, 32'h0, 32'h3}, 5, -1);
    finish_result(1'b1, 0);

    // Reset while word 4 is on the bus
    send_job(64'hAA, 64'hBB, 128'hCC, 32'd32);
    axis.m_axis_tready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      void'(exp_q.pop_front());
    end
    chk("word4_before_rst", 256'(axis.m_axis_tdata), 256'(exp_q[0]));
    reset_n = 1'b0;
    #1;
    axis.m_axis_tready = 1'b0;
    chk_reset_values("midrst");
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    send_job(64'h10, 64'h20, 128'hDEADBEEF_00000001, 32'd32);
    drain_send(1'b0);
    recv({32'h6, 32'h7, 32'h8, 32'h9, 32'h0, 32'h20}, -1, -1);
    finish_result(1'b0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
